crc_frame_serializer: RTL and testbench
=======================================

# crc_frame_serializer

Downstream stage of the CRC encoder. Takes a data word plus its computed CRC remainder over a valid/ready handshake and emits the codeword one bit per transfer, MSB first. Serial output has frame-start and frame-end markers and honours downstream back-pressure. A one-word holding buffer lets the next word be accepted while the current frame is still shifting, so frames can go out back-to-back.

## Interface
- DATAWIDTH, 10, data word width in bits.
- CRCWIDTH, 4, CRC remainder width in bits.
- clk  input  1  clock; all logic on its rising edge.
- resetn  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data/in_crc hold a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATAWIDTH  data word.
- in_crc  input  CRCWIDTH  CRC remainder for in_data.
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  downstream takes ser_bit this cycle.
- ser_bit  output  1  current serial bit.
- ser_sof  output  1  ser_bit is the first bit of a frame.
- ser_eof  output  1  ser_bit is the last bit of a frame.

## Operation
- Frame = {in_data, in_crc} (+ parity bit if enabled). FLEN = DATAWIDTH+CRCWIDTH (+1).
- Transmission order: in_data[DATAWIDTH-1] first, in_crc[0] last, before any parity bit.
- Input accept: in_valid && in_ready at a rising edge.
- Bit transfer: ser_valid && ser_ready at a rising edge.
- Storage is a shift register (SR) with a bit counter, plus a hold register (HR) with a full flag.
- in_ready = !hb_full. It is forced to 0 while resetn is low.
- FSM states:
  - IDLE: SR empty, ser_valid=0.
  - SHIFT: SR loaded, ser_valid=1.
- Accept in IDLE with HR empty: the word loads directly into SR and the FSM goes to SHIFT.
- Accept in SHIFT: the word goes to HR and hb_full is set.
- Transfer of a non-last bit: SR shifts left by one and the counter increments.
- Transfer of the last bit (counter == FLEN-1):
  - HR full: SR loads from HR, hb_full clears, counter resets to 0, state stays SHIFT (no gap).
  - HR empty: state goes to IDLE.
- Simultaneous last-bit transfer and input accept with HR empty (in_ready=1): the incoming word loads straight into SR and the FSM stays in SHIFT.
- Outputs:
  - ser_bit = SR MSB.
  - ser_sof = SHIFT && counter==0.
  - ser_eof = SHIFT && counter==FLEN-1.
- ser_ready low: SR, counter and outputs are held. HR may still fill.
- Counter width: $clog2(FLEN). Counter never exceeds FLEN-1.

## Timing
- Reset values:
  - ser_valid=0, ser_bit=0, ser_sof=0, ser_eof=0.
  - hb_full=0; in_ready=0 while in reset, 1 in the first cycle after resetn goes high.
  - State IDLE, counter 0.
- Latency: word accepted at edge N in IDLE gives ser_valid=1 with ser_sof=1 in the cycle after N.
- Sustained throughput: one frame per FLEN transfers with ser_ready held high.
- Outputs are registered or decoded from registered state only. No combinational path from in_valid or ser_ready to any ser_* output.
- in_ready depends only on registered state.
- Reset mid-frame: the frame is discarded and HR is cleared. No partial frame resumes.

## Configuration
- CRC_SER_PARITY_EN:
  - Defined: FLEN gains one bit, appended after in_crc[0]. It is the odd-parity bit over data+CRC (total ones in frame odd). ser_eof marks the parity bit.
  - Undefined: FLEN = DATAWIDTH+CRCWIDTH, no parity logic.

## Structure
- Shared package crc_pkg holds:
  - state enum (IDLE, SHIFT);
  - default DATAWIDTH/CRCWIDTH constants;
  - function computing FLEN from widths and the macro setting.
- One sub-module is natural: crc_hold_buffer, a one-entry valid/ready register slice for HR.

## Test plan
- Single frame: data=10'b1101011011, crc=4'b1110, ser_ready=1.
  - Without macro: bits 1,1,0,1,0,1,1,0,1,1,1,1,1,0; sof on bit 1, eof on bit 14; then ser_valid=0.
- Same frame with CRC_SER_PARITY_EN: 15 bits, 15th bit=1 (10 ones in data+CRC); eof on bit 15.
- Back-to-back: second word (10'h3FF, 4'h0) presented during first frame.
  - in_ready drops after the second accept.
  - The second frame's sof follows the first frame's eof with no idle cycle.
- Back-pressure: ser_ready low for 5 cycles at bit 7 → ser_bit, ser_sof and ser_eof are stable throughout; the frame completes with correct 14 bits.
- Simultaneous: HR empty, new word accepted on the same edge as the last-bit transfer → next cycle ser_sof=1 with the new word's MSB.
- Reset mid-frame at bit 5 with HR full → after release, ser_valid=0 and in_ready=1; the next word is serialized in full from sof.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and sizing helpers for the CRC frame serializer.
// Frame length depends on the optional CRC_SER_PARITY_EN macro.
package crc_pkg;

    localparam int DATAWIDTH_DEF = 10;
    localparam int CRCWIDTH_DEF  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } crc_state_e;

    function automatic int crc_flen(input int dw, input int cw);
`ifdef CRC_SER_PARITY_EN
        return dw + cw + 1;
`else
        return dw + cw;
`endif
    endfunction

endpackage

// File: rtl/crc_frame_serializer_if.sv
// Word-input and serial-output handshake bundle of the CRC frame serializer.
// slave = serializer side, master = the surrounding producer/consumer side.
interface crc_frame_serializer_if
    import crc_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int CRCWIDTH  = CRCWIDTH_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_data;
    logic [CRCWIDTH-1:0]  in_crc;
    logic                 ser_valid;
    logic                 ser_ready;
    logic                 ser_bit;
    logic                 ser_sof;
    logic                 ser_eof;

    modport slave (
        input  in_valid, in_data, in_crc, ser_ready,
        output in_ready, ser_valid, ser_bit, ser_sof, ser_eof
    );

    modport master (
        output in_valid, in_data, in_crc, ser_ready,
        input  in_ready, ser_valid, ser_bit, ser_sof, ser_eof
    );
endinterface

// File: rtl/crc_hold_buffer.sv
// One-entry holding register for the next {data, crc} word while a frame shifts.
// push and pop are never asserted together: push needs empty, pop needs full.
module crc_hold_buffer #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] data
);
    logic             full_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            full_reg <= 1'b0;
        end else if (push) begin
            full_reg <= 1'b1;
        end else if (pop) begin
            full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_reg <= push_data;
        end
    end

    assign full = full_reg;
    assign data = data_reg;
endmodule

// File: rtl/crc_frame_serializer.sv
// Serializes {data, crc} words MSB first with sof/eof markers and back-pressure.
// Optional odd-parity trailer bit when CRC_SER_PARITY_EN is defined.
module crc_frame_serializer
    import crc_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int CRCWIDTH  = CRCWIDTH_DEF
) (
    input  logic clk,
    input  logic resetn,
    crc_frame_serializer_if.slave bus
);
    localparam int FLEN = crc_flen(DATAWIDTH, CRCWIDTH);
    localparam int CW   = $clog2(FLEN);
    localparam int WW   = DATAWIDTH + CRCWIDTH;

    crc_state_e      state_reg, state_next;
    logic [FLEN-1:0] sr_reg, sr_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic            hb_full;
    logic [WW-1:0]   hb_data;
    logic            accept, xfer, last, hb_push, hb_pop;

    function automatic logic [FLEN-1:0] frame_of(input logic [WW-1:0] word);
`ifdef CRC_SER_PARITY_EN
        return {word, ~(^word)};
`else
        return word;
`endif
    endfunction

    assign bus.in_ready = resetn && !hb_full;
    assign accept  = bus.in_valid && bus.in_ready;
    assign xfer    = (state_reg == SHIFT) && bus.ser_ready;
    assign last    = (cnt_reg == CW'(FLEN - 1));
    // A word goes to HR only if SR can't take it on this very edge.
    assign hb_push = accept && (state_reg == SHIFT) && !(xfer && last);
    assign hb_pop  = xfer && last && hb_full;

    crc_hold_buffer #(.WIDTH(WW)) u_hold (
        .clk       (clk),
        .resetn    (resetn),
        .push      (hb_push),
        .push_data ({bus.in_data, bus.in_crc}),
        .pop       (hb_pop),
        .full      (hb_full),
        .data      (hb_data)
    );

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    sr_next    = frame_of({bus.in_data, bus.in_crc});
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (!last) begin
                        sr_next  = {sr_reg[FLEN-2:0], 1'b0};
                        cnt_next = cnt_reg + CW'(1);
                    end else if (hb_full) begin
                        sr_next  = frame_of(hb_data);
                        cnt_next = '0;
                    end else if (accept) begin
                        sr_next  = frame_of({bus.in_data, bus.in_crc});
                        cnt_next = '0;
                    end else begin
                        sr_next    = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.ser_valid = (state_reg == SHIFT);
    assign bus.ser_bit   = (state_reg == SHIFT) && sr_reg[FLEN-1];
    assign bus.ser_sof   = (state_reg == SHIFT) && (cnt_reg == '0);
    assign bus.ser_eof   = (state_reg == SHIFT) && last;
endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer; expected frames are hand-written constants.
// Works in both builds (with or without CRC_SER_PARITY_EN).
module tb_crc_frame_serializer;
    import crc_pkg::*;

    localparam int DW   = 10;
    localparam int CRW  = 4;
    localparam int FLEN = crc_flen(DW, CRW);

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    // Full 15-bit frames including parity; without parity only bits [14:1] are sent.
    logic [14:0] e1;
    logic [14:0] e2;

    crc_frame_serializer_if #(.DATAWIDTH(DW), .CRCWIDTH(CRW)) bus ();

    crc_frame_serializer #(.DATAWIDTH(DW), .CRCWIDTH(CRW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic b,
                             input logic s, input logic e);
        check({tag, ".valid"}, 32'(bus.ser_valid), 32'(v));
        check({tag, ".bit"},   32'(bus.ser_bit),   32'(b));
        check({tag, ".sof"},   32'(bus.ser_sof),   32'(s));
        check({tag, ".eof"},   32'(bus.ser_eof),   32'(e));
    endtask

    // Checks bits [from..to] of a frame, one transfer per cycle.
    task automatic check_bits(input string tag, input logic [14:0] exp_frame,
                              input int from, input int to);
        for (int i = from; i <= to; i++) begin
            check_out($sformatf("%s.b%0d", tag, i), 1'b1, exp_frame[14-i],
                      (i == 0), (i == FLEN - 1));
            @(negedge clk);
        end
        $display("frame %s: bits %0d..%0d checked", tag, from, to);
    endtask

    task automatic send(input string tag, input logic [DW-1:0] d, input logic [CRW-1:0] c);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_crc   = c;
        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("word %s: data=%03h crc=%0h accepted", tag, d, c);
    endtask

    initial begin
        clk = 1'b0;
        resetn = 1'b0;
        n_checks = 0;
        n_fail = 0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_crc = '0;
        bus.ser_ready = 1'b1;
        e1 = 15'b110101101111101;
        e2 = 15'b111111111100001;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        check_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        @(negedge clk);
        check("rel.in_ready", 32'(bus.in_ready), 32'd1);
        check_out("rel", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single frame, latency of one cycle to sof
        send("single", 10'b1101011011, 4'b1110);
        check_bits("single", e1, 0, FLEN - 1);
        check_out("single.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames through the hold register
        send("b2b1", 10'b1101011011, 4'b1110);
        check_bits("b2b1", e1, 0, 0);
        send("b2b2", 10'h3FF, 4'h0);
        check("b2b.in_ready", 32'(bus.in_ready), 32'd0);
        check_bits("b2b1", e1, 2, FLEN - 1);
        check_bits("b2b2", e2, 0, FLEN - 1);
        check_out("b2b.after", 1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b.in_ready_end", 32'(bus.in_ready), 32'd1);

        // Back-pressure held at bit 7 for 5 cycles
        send("bp", 10'b1101011011, 4'b1110);
        check_bits("bp", e1, 0, 6);
        bus.ser_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_out($sformatf("bp.hold%0d", k), 1'b1, e1[14-7], 1'b0, 1'b0);
            @(negedge clk);
        end
        bus.ser_ready = 1'b1;
        check_bits("bp", e1, 7, FLEN - 1);
        check_out("bp.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // New word accepted on the same edge as the last-bit transfer
        send("sim1", 10'b1101011011, 4'b1110);
        check_bits("sim1", e1, 0, FLEN - 2);
        check_out("sim1.last", 1'b1, e1[14-(FLEN-1)], 1'b0, 1'b1);
        send("sim2", 10'h3FF, 4'h0);
        check_bits("sim2", e2, 0, FLEN - 1);
        check_out("sim.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame at bit 5 with the hold register full
        send("mid1", 10'b1101011011, 4'b1110);
        check_bits("mid1", e1, 0, 0);
        send("mid2", 10'h3FF, 4'h0);
        check("mid.hr_full", 32'(bus.in_ready), 32'd0);
        check_bits("mid1", e1, 2, 4);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid.rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_out("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        @(negedge clk);
        check_out("mid.rel", 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid.rel_in_ready", 32'(bus.in_ready), 32'd1);
        send("mid3", 10'h3FF, 4'h0);
        check_bits("mid3", e2, 0, FLEN - 1);
        check_out("mid3.after", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
